alu_issue_ctrl: RTL and testbench
=================================

# alu_issue_ctrl

Sequential front-end for the combinational `alu_32bit`. It accepts operation commands over a valid/ready handshake, registers them, and drives the ALU's `op1`/`op2`/`opsel`/`mode` pins from those registers. It then captures `result` and the four flags into a response register, which it presents over a second valid/ready handshake. It sits between the processor's decode/issue stage and `alu_32bit`, and it also keeps operation and error counters.

## Interface
Parameters:
- `DWIDTH`, 32, operand/result width (must match `alu_32bit`)
- `TWIDTH`, 4, command tag width

Ports:
- `clk`  in  1  single clock; all state updates on rising edge
- `rst`  in  1  asynchronous, active-high reset
- `cmd_valid`  in  1  command present
- `cmd_ready`  out  1  controller can accept a command
- `cmd_op`  in  4  {mode, opsel[2:0]}; legal: 0 add, 1 subwb, 2 mov, 3 sub, 4 inc, 5 dec, 6 addinc, 8 and, 9 or, A xor, B not, D shl
- `cmd_a`  in  DWIDTH  operand 1
- `cmd_b`  in  DWIDTH  operand 2
- `cmd_use_prev`  in  1  replace operand 1 with last committed result
- `cmd_tag`  in  TWIDTH  returned unchanged with response
- `alu_op1`, `alu_op2`  out  DWIDTH  to ALU `op1`/`op2`
- `alu_opsel`  out  3  to ALU `opsel` (= `cmd_op[2:0]` registered)
- `alu_mode`  out  1  to ALU `mode` (= `cmd_op[3]` registered)
- `alu_result`  in  DWIDTH  from ALU `result`
- `alu_c`, `alu_z`, `alu_o`, `alu_s`  in  1 each  from ALU flags
- `rsp_valid`  out  1  response present
- `rsp_ready`  in  1  consumer accepts response
- `rsp_result`  out  DWIDTH  captured result
- `rsp_flags`  out  4  {c, z, o, s}
- `rsp_tag`  out  TWIDTH  tag of command
- `rsp_err`  out  1  illegal opcode
- `op_count`  out  16  responses delivered, wraps
- `err_count`  out  8  illegal-op responses delivered, saturates at 255

## Operation
- Three-state FSM:
  - IDLE: `cmd_ready`=1. `cmd_valid` goes to EXEC and latches op, operands, tag and `use_prev`.
  - EXEC: ALU driven from the latched registers. At the clock edge, capture into the response registers and go to HOLD with `rsp_valid`=1.
  - HOLD: `rsp_valid`=1 until `rsp_ready`.
    - `rsp_ready` with `cmd_valid`: go to EXEC with the new command latched (back-to-back).
    - `rsp_ready` without `cmd_valid`: go to IDLE.
- `cmd_ready` = (state==IDLE) | (state==HOLD & `rsp_ready`). Combinational from `rsp_ready`, with no dependency on `cmd_valid`.
- Operand 1 source:
  - `use_prev`=1: `prev_result`, the last response with `rsp_err`=0 that completed a handshake; 0 after reset.
  - Otherwise `cmd_a`.
  - Resolved at latch time. For a back-to-back accept in HOLD, the response being handed over in that same cycle is the one used.
- Illegal opcodes 7, C, E, F:
  - ALU pins are still driven.
  - Response has `rsp_err`=1, `rsp_result`=0, `rsp_flags`=0.
  - `prev_result` is not updated.
- Counters update only on the response handshake (`rsp_valid` & `rsp_ready`).
  - `op_count` increments by 1 and wraps from FFFF to 0000.
  - `err_count` increments by 1 if `rsp_err`, holding at 255.
- Response registers stay stable while `rsp_valid`=1 and `rsp_ready`=0.

## Timing
- Reset values (asynchronous, immediate):
  - state=IDLE, `cmd_ready`=1, `rsp_valid`=0.
  - `rsp_result`/`rsp_flags`/`rsp_tag`/`rsp_err`=0.
  - `alu_op1`/`alu_op2`/`alu_opsel`/`alu_mode`=0.
  - `prev_result`=0, `op_count`=0, `err_count`=0.
- Latency: command accepted at edge N, so `rsp_valid`=1 after edge N+1.
- Throughput: one op per 2 cycles with `rsp_ready` held high.
- ALU inputs stay stable from edge N through edge N+1. ALU outputs are sampled only at the EXEC edge.
- Reset mid-operation discards the in-flight command and the pending response. No counter update.
- The `rsp_ready` handshake in IDLE or EXEC is ignored.

## Test plan
- Reset: assert `rst` asynchronously mid-HOLD → `rsp_valid` drops immediately, `cmd_ready`=1, counters 0.
- add: `op` 0, a=5, b=7, tag=3 → `rsp_valid` two edges after accept; result 12, flags {0,0,0,0}, tag 3. Then sub: `op` 3, a=b=0x1234 → result 0, z=1.
- Back-to-back with `rsp_ready`=1: issue add(1,2) then xor(`use_prev`=1, b=0xF) → second result 0x3^0xF=0xC. Responses arrive on alternate cycles and `op_count`=2.
- Backpressure: `rsp_ready`=0 for 5 cycles → `rsp_result`/`rsp_tag` stable, `cmd_ready`=0. Release → handshake and IDLE.
- Illegal `op` 0xC, a=1 → `rsp_err`=1, result 0, `err_count`=1. Following `use_prev` inc → result = previous legal result + 1.
- Saturation/wrap: 256 illegal ops → `err_count` stays 255. Preload `op_count` via 65536 ops (long test) → wraps to 0.

Source files
------------

// File: rtl/alu_issue_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// alu_issue_ctrl : valid/ready issue front-end for alu_32bit with response
//                  capture and op/error counters.          Rev 1.0
// ----------------------------------------------------------------------------
module alu_issue_ctrl #(
  parameter int DWIDTH = 32,
  parameter int TWIDTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [DWIDTH-1:0] cmd_a,
  input  logic [DWIDTH-1:0] cmd_b,
  input  logic              cmd_use_prev,
  input  logic [TWIDTH-1:0] cmd_tag,
  output logic [DWIDTH-1:0] alu_op1,
  output logic [DWIDTH-1:0] alu_op2,
  output logic [2:0]        alu_opsel,
  output logic              alu_mode,
  input  logic [DWIDTH-1:0] alu_result,
  input  logic              alu_c,
  input  logic              alu_z,
  input  logic              alu_o,
  input  logic              alu_s,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DWIDTH-1:0] rsp_result,
  output logic [3:0]        rsp_flags,
  output logic [TWIDTH-1:0] rsp_tag,
  output logic              rsp_err,
  output logic [15:0]       op_count,
  output logic [7:0]        err_count
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_EXEC = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  logic [1:0]        state_q, state_d;
  logic [DWIDTH-1:0] op1_q, op1_d;
  logic [DWIDTH-1:0] op2_q, op2_d;
  logic [3:0]        op_q, op_d;
  logic [TWIDTH-1:0] tag_q, tag_d;
  logic [DWIDTH-1:0] rsp_result_q, rsp_result_d;
  logic [3:0]        rsp_flags_q, rsp_flags_d;
  logic [TWIDTH-1:0] rsp_tag_q, rsp_tag_d;
  logic              rsp_err_q, rsp_err_d;
  logic [DWIDTH-1:0] prev_q, prev_d;
  logic [15:0]       op_cnt_q, op_cnt_d;
  logic [7:0]        err_cnt_q, err_cnt_d;

  logic accept;
  logic rsp_hs;
  logic illegal;

  assign rsp_hs    = (state_q == S_HOLD) & rsp_ready;
  assign cmd_ready = (state_q == S_IDLE) | rsp_hs;
  assign accept    = cmd_valid & cmd_ready;
  assign illegal   = (op_q == 4'h7) | (op_q == 4'hC) | (op_q[3:1] == 3'b111);

  always_comb begin
    state_d      = state_q;
    op1_d        = op1_q;
    op2_d        = op2_q;
    op_d         = op_q;
    tag_d        = tag_q;
    rsp_result_d = rsp_result_q;
    rsp_flags_d  = rsp_flags_q;
    rsp_tag_d    = rsp_tag_q;
    rsp_err_d    = rsp_err_q;
    prev_d       = prev_q;
    op_cnt_d     = op_cnt_q;
    err_cnt_d    = err_cnt_q;

    if (rsp_hs) begin
      op_cnt_d = op_cnt_q + 16'd1;
      if (rsp_err_q) begin
        if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
      end else begin
        prev_d = rsp_result_q;
      end
    end

    // prev_d already reflects a response handed over in this same cycle
    if (accept) begin
      op1_d = cmd_use_prev ? prev_d : cmd_a;
      op2_d = cmd_b;
      op_d  = cmd_op;
      tag_d = cmd_tag;
    end

    case (state_q)
      S_IDLE: if (cmd_valid) state_d = S_EXEC;
      S_EXEC: begin
        state_d      = S_HOLD;
        rsp_err_d    = illegal;
        rsp_result_d = illegal ? '0 : alu_result;
        rsp_flags_d  = illegal ? 4'h0 : {alu_c, alu_z, alu_o, alu_s};
        rsp_tag_d    = tag_q;
      end
      S_HOLD: if (rsp_ready) state_d = cmd_valid ? S_EXEC : S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      op1_q        <= '0;
      op2_q        <= '0;
      op_q         <= 4'h0;
      tag_q        <= '0;
      rsp_result_q <= '0;
      rsp_flags_q  <= 4'h0;
      rsp_tag_q    <= '0;
      rsp_err_q    <= 1'b0;
      prev_q       <= '0;
      op_cnt_q     <= 16'h0;
      err_cnt_q    <= 8'h0;
    end else begin
      state_q      <= state_d;
      op1_q        <= op1_d;
      op2_q        <= op2_d;
      op_q         <= op_d;
      tag_q        <= tag_d;
      rsp_result_q <= rsp_result_d;
      rsp_flags_q  <= rsp_flags_d;
      rsp_tag_q    <= rsp_tag_d;
      rsp_err_q    <= rsp_err_d;
      prev_q       <= prev_d;
      op_cnt_q     <= op_cnt_d;
      err_cnt_q    <= err_cnt_d;
    end
  end

  assign alu_op1    = op1_q;
  assign alu_op2    = op2_q;
  assign alu_opsel  = op_q[2:0];
  assign alu_mode   = op_q[3];
  assign rsp_valid  = (state_q == S_HOLD);
  assign rsp_result = rsp_result_q;
  assign rsp_flags  = rsp_flags_q;
  assign rsp_tag    = rsp_tag_q;
  assign rsp_err    = rsp_err_q;
  assign op_count   = op_cnt_q;
  assign err_count  = err_cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_alu_issue_ctrl.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_alu_issue_ctrl : directed bench with a transaction-level reference model
//                     and a behavioural stand-in for alu_32bit.   Rev 1.0
// ----------------------------------------------------------------------------
module tb_alu_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [3:0]  cmd_op;
  logic [31:0] cmd_a;
  logic [31:0] cmd_b;
  logic        cmd_use_prev;
  logic [3:0]  cmd_tag;
  logic [31:0] alu_op1;
  logic [31:0] alu_op2;
  logic [2:0]  alu_opsel;
  logic        alu_mode;
  logic [31:0] alu_result;
  logic        alu_c, alu_z, alu_o, alu_s;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_result;
  logic [3:0]  rsp_flags;
  logic [3:0]  rsp_tag;
  logic        rsp_err;
  logic [15:0] op_count;
  logic [7:0]  err_count;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  alu_issue_ctrl #(.DWIDTH(32), .TWIDTH(4)) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_use_prev(cmd_use_prev), .cmd_tag(cmd_tag),
    .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_opsel(alu_opsel), .alu_mode(alu_mode),
    .alu_result(alu_result), .alu_c(alu_c), .alu_z(alu_z), .alu_o(alu_o), .alu_s(alu_s),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
    .rsp_flags(rsp_flags), .rsp_tag(rsp_tag), .rsp_err(rsp_err),
    .op_count(op_count), .err_count(err_count)
  );

  // Stand-in ALU: returns {result, c, z, o, s}; illegal opcodes give junk so
  // that the controller's zeroing is visible.
  function automatic logic [35:0] alu_fn(input logic [3:0] op, input logic [31:0] a,
                                         input logic [31:0] b);
    logic [32:0] w;
    logic [31:0] r;
    case (op)
      4'h0: w = {1'b0, a} + {1'b0, b};
      4'h1: w = {1'b0, a} - {1'b0, b} - 33'd1;
      4'h2: w = {1'b0, a};
      4'h3: w = {1'b0, a} - {1'b0, b};
      4'h4: w = {1'b0, a} + 33'd1;
      4'h5: w = {1'b0, a} - 33'd1;
      4'h6: w = {1'b0, a} + {1'b0, b} + 33'd1;
      4'h8: w = {1'b0, a & b};
      4'h9: w = {1'b0, a | b};
      4'hA: w = {1'b0, a ^ b};
      4'hB: w = {1'b0, ~a};
      4'hD: w = {a, 1'b0};
      default: w = {1'b1, a ^ 32'hDEADBEEF};
    endcase
    r = w[31:0];
    return {r, w[32], (r == 32'h0), a[31] ^ r[31], r[31]};
  endfunction

  assign {alu_result, alu_c, alu_z, alu_o, alu_s} = alu_fn({alu_mode, alu_opsel}, alu_op1, alu_op2);

  function automatic logic is_illegal(input logic [3:0] op);
    return (op == 4'h7) || (op == 4'hC) || (op == 4'hE) || (op == 4'hF);
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Reference model: one outstanding transaction at most
  logic        m_pend;
  logic [31:0] m_res;
  logic [3:0]  m_flags;
  logic [3:0]  m_tag;
  logic        m_err;
  int          m_rdy_at;
  logic [31:0] m_prev;
  logic [15:0] m_ops;
  logic [7:0]  m_errs;
  logic        m_rv, m_cr;
  logic [31:0] m_a;
  logic [35:0] m_f;

  initial begin
    m_pend = 0; m_prev = 0; m_ops = 0; m_errs = 0; m_rdy_at = 0;
    m_res = 0; m_flags = 0; m_tag = 0; m_err = 0;
    forever begin
      @(negedge clk);
      if (rst) begin
        m_pend = 0; m_prev = 0; m_ops = 0; m_errs = 0;
      end else begin
        m_rv = m_pend && (cyc >= m_rdy_at);
        m_cr = !m_pend || (m_rv && rsp_ready);
        chk("rsp_valid", {31'd0, rsp_valid}, {31'd0, m_rv});
        chk("cmd_ready", {31'd0, cmd_ready}, {31'd0, m_cr});
        chk("op_count", {16'd0, op_count}, {16'd0, m_ops});
        chk("err_count", {24'd0, err_count}, {24'd0, m_errs});
        if (m_rv) begin
          chk("rsp_result", rsp_result, m_res);
          chk("rsp_flags", {28'd0, rsp_flags}, {28'd0, m_flags});
          chk("rsp_tag", {28'd0, rsp_tag}, {28'd0, m_tag});
          chk("rsp_err", {31'd0, rsp_err}, {31'd0, m_err});
        end
        if (m_rv && rsp_ready) begin
          m_pend = 0;
          m_ops  = m_ops + 16'd1;
          if (m_err) begin
            if (m_errs != 8'd255) m_errs = m_errs + 8'd1;
          end else begin
            m_prev = m_res;
          end
        end
        if (cmd_valid && m_cr) begin
          m_a = cmd_use_prev ? m_prev : cmd_a;
          m_f = alu_fn(cmd_op, m_a, cmd_b);
          m_err   = is_illegal(cmd_op);
          m_res   = m_err ? 32'h0 : m_f[35:4];
          m_flags = m_err ? 4'h0 : m_f[3:0];
          m_tag   = cmd_tag;
          m_pend  = 1;
          m_rdy_at = cyc + 2;
        end
      end
    end
  end

  // All driver tasks start and end just after a rising edge
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                      input logic up, input logic [3:0] tag);
    logic ok;
    ok = 0;
    cmd_valid = 1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_use_prev = up; cmd_tag = tag;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = cmd_ready;
      @(posedge clk);
      #1;
    end
    cmd_valid = 0;
    if (!ok) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Returns on the falling edge where rsp_valid is seen
  task automatic wait_rsp();
    logic ok;
    ok = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = rsp_valid;
    end
    if (!ok) chk("rsp_timeout", 32'd0, 32'd1);
  endtask

  task automatic take();
    @(posedge clk);
    #1 rsp_ready = 1;
    @(posedge clk);
    #1 rsp_ready = 0;
  endtask

  logic [3:0] t_op  [8] = '{4'h1, 4'h2, 4'h4, 4'h5, 4'h6, 4'h8, 4'hB, 4'hD};
  logic [3:0] ill_op[4] = '{4'h7, 4'hC, 4'hE, 4'hF};

  initial begin
    rst = 1; cmd_valid = 0; cmd_op = 0; cmd_a = 0; cmd_b = 0; cmd_use_prev = 0;
    cmd_tag = 0; rsp_ready = 0;
    #1;
    chk("reset_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("reset_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("reset_alu_op1", alu_op1, 32'd0);
    chk("reset_rsp_result", rsp_result, 32'd0);
    repeat (2) @(negedge clk);
    @(posedge clk);
    #1 rst = 0;

    // add then sub, one at a time
    send(4'h0, 32'd5, 32'd7, 1'b0, 4'd3);
    chk("add_latency_not_yet", {31'd0, rsp_valid}, 32'd0);
    wait_rsp();
    chk("add_result", rsp_result, 32'd12);
    chk("add_flags", {28'd0, rsp_flags}, 32'h0);
    chk("add_tag", {28'd0, rsp_tag}, 32'd3);
    take();
    chk("add_op_count", {16'd0, op_count}, 32'd1);
    send(4'h3, 32'h1234, 32'h1234, 1'b0, 4'd4);
    wait_rsp();
    chk("sub_result", rsp_result, 32'd0);
    chk("sub_flags", {28'd0, rsp_flags}, 32'h4);

    // asynchronous reset while the sub response is held
    #2 rst = 1;
    #1;
    chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("rst_cmd_ready", {31'd0, cmd_ready}, 32'd1);
    chk("rst_op_count", {16'd0, op_count}, 32'd0);
    @(negedge clk);
    @(posedge clk);
    #1 rst = 0;

    // back-to-back: xor consumes the add result handed over in the same cycle
    rsp_ready = 1;
    send(4'h0, 32'd1, 32'd2, 1'b0, 4'd1);
    send(4'hA, 32'hFFFF_0000, 32'hF, 1'b1, 4'd2);
    wait_rsp();
    chk("b2b_xor_result", rsp_result, 32'hC);
    @(posedge clk);
    #1;
    chk("b2b_op_count", {16'd0, op_count}, 32'd2);
    rsp_ready = 0;

    // backpressure
    send(4'h9, 32'hF0, 32'h0F, 1'b0, 4'd5);
    wait_rsp();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_result", rsp_result, 32'hFF);
      chk("bp_tag", {28'd0, rsp_tag}, 32'd5);
      chk("bp_cmd_ready", {31'd0, cmd_ready}, 32'd0);
    end
    take();
    chk("bp_idle_ready", {31'd0, cmd_ready}, 32'd1);
    chk("bp_idle_valid", {31'd0, rsp_valid}, 32'd0);

    // illegal opcode, then use_prev must skip it
    send(4'hC, 32'd1, 32'd2, 1'b0, 4'd9);
    wait_rsp();
    chk("ill_err", {31'd0, rsp_err}, 32'd1);
    chk("ill_result", rsp_result, 32'd0);
    chk("ill_flags", {28'd0, rsp_flags}, 32'd0);
    take();
    chk("ill_err_count", {24'd0, err_count}, 32'd1);
    send(4'h4, 32'hDEAD, 32'd0, 1'b1, 4'd1);
    wait_rsp();
    chk("inc_prev_result", rsp_result, 32'h100);
    take();

    // remaining legal opcodes, model-checked
    rsp_ready = 1;
    for (int i = 0; i < 8; i++)
      send(t_op[i], 32'h8000_0000 + i * 32'h1111, i * 3, i[0], i[3:0]);
    repeat (3) @(posedge clk);
    #1;

    // error counter saturation
    for (int i = 0; i < 257; i++)
      send(ill_op[i % 4], i, 32'd1, 1'b0, 4'hE);
    repeat (3) @(posedge clk);
    #1;
    chk("sat_err_count", {24'd0, err_count}, 32'd255);
    chk("total_op_count", {16'd0, op_count}, 32'd270);
    rsp_ready = 0;
    repeat (2) @(posedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
